// File: rtl/load_store_pkg.sv
// Shared load/store definitions used by the load alignment unit and by the
// store-side mask logic.
//   - F3_* : RISC-V load func3 encodings
//   - lsu_state_t : load tracking state (IDLE / WAIT)
//   - load_legal() : true when a func3/offset pair is a legal, aligned load
package load_store_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // Halfwords must sit on an even byte, words on a word boundary.
    // Encodings 011/110/111 are not loads and are rejected outright.
    function automatic logic load_legal(input logic [2:0] func3,
                                        input logic [1:0] offset);
        case (func3)
            F3_LB, F3_LBU: load_legal = 1'b1;
            F3_LH, F3_LHU: load_legal = ~offset[0];
            F3_LW:         load_legal = (offset == 2'b00);
            default:       load_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and extension of a word-aligned read word.
// Ports:
//   func3  in  3      load type of the captured load
//   offset in  2      byte offset inside the word
//   rdata  in  WIDTH  word-aligned memory read data
//   data   out WIDTH  selected byte/half/word, sign- or zero-extended
module load_extract
    import load_store_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       func3,
    input  logic [1:0]       offset,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane k lives at bits 8k+7:8k; the half lane is picked by offset[1].
    assign byte_sel = rdata[{offset, 3'b000} +: 8];
    assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: data gets a default before the case so every path assigns it and no latch is inferred.
        data = rdata;
        case (func3)
            F3_LB:   data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(WIDTH-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load-side alignment unit between the X-stage load request and the data
// memory read port. Tracks one outstanding load, stalls the pipeline until
// its response arrives, then writes back the aligned, extended result.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load_X_i            valid load in X
//   func3_X_i           load func3
//   byte_offset_X_i     addr[1:0] of the load
//   rd_X_i              destination register
//   flush_i             kill X request and any outstanding load
//   mem_resp_valid_i    read data valid
//   mem_rdata_i         word-aligned read data
//   stall_o             comb: load outstanding with no response this cycle
//   wb_valid_o          registered pulse: wb_data_o / wb_rd_o valid
//   wb_data_o           registered load result (holds when not valid)
//   wb_rd_o             registered destination register (holds when not valid)
//   misaligned_o        registered pulse: load rejected
module load_align_unit
    import load_store_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_X_i,
    input  logic [2:0]       func3_X_i,
    input  logic [1:0]       byte_offset_X_i,
    input  logic [RD_W-1:0]  rd_X_i,
    input  logic             flush_i,
    input  logic             mem_resp_valid_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             stall_o,
    output logic             wb_valid_o,
    output logic [WIDTH-1:0] wb_data_o,
    output logic [RD_W-1:0]  wb_rd_o,
    output logic             misaligned_o
);

    lsu_state_t       state_q, state_d;
    logic [2:0]       func3_q;
    logic [1:0]       offset_q;
    logic [RD_W-1:0]  rd_q;
    logic [WIDTH-1:0] extracted;

    logic resp_fire;   // outstanding load completes this cycle
    logic slot_open;   // a new X-stage load may be accepted this cycle
    logic capture;
    logic reject;

    // Extraction works on the captured fields; the X-stage fields may already
    // belong to the next load in a back-to-back cycle.
    load_extract #(.WIDTH(WIDTH)) u_extract (
        .func3  (func3_q),
        .offset (offset_q),
        .rdata  (mem_rdata_i),
        .data   (extracted)
    );

    // Flush dominates everything: no completion, no capture, no rejection.
    assign resp_fire = (state_q == WAIT) && mem_resp_valid_i && !flush_i;
    assign slot_open = !flush_i && ((state_q == IDLE) || resp_fire);
    assign capture   = slot_open && load_X_i &&  load_legal(func3_X_i, byte_offset_X_i);
    assign reject    = slot_open && load_X_i && !load_legal(func3_X_i, byte_offset_X_i);
    assign stall_o   = (state_q == WAIT) && !mem_resp_valid_i && !flush_i;

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (capture) begin
            state_d = WAIT;
        end else if (resp_fire || reject) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: every register here is reset, including the captured fields and the hold-value writeback bus.
        if (rst) begin
            func3_q      <= '0;
            offset_q     <= '0;
            rd_q         <= '0;
            wb_valid_o   <= 1'b0;
            wb_data_o    <= '0;
            wb_rd_o      <= '0;
            misaligned_o <= 1'b0;
        end else begin
            wb_valid_o   <= resp_fire;
            misaligned_o <= reject;
            if (resp_fire) begin
                wb_data_o <= extracted;
                wb_rd_o   <= rd_q;
            end
            if (capture) begin
                func3_q  <= func3_X_i;
                offset_q <= byte_offset_X_i;
                rd_q     <= rd_X_i;
            end
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit.
module tb_load_align_unit;
    import load_store_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_X_i;
    logic [2:0]  func3_X_i;
    logic [1:0]  byte_offset_X_i;
    logic [4:0]  rd_X_i;
    logic        flush_i;
    logic        mem_resp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;

    load_align_unit dut (
        .clk              (clk),
        .rst              (rst),
        .load_X_i         (load_X_i),
        .func3_X_i        (func3_X_i),
        .byte_offset_X_i  (byte_offset_X_i),
        .rd_X_i           (rd_X_i),
        .flush_i          (flush_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i),
        .stall_o          (stall_o),
        .wb_valid_o       (wb_valid_o),
        .wb_data_o        (wb_data_o),
        .wb_rd_o          (wb_rd_o),
        .misaligned_o     (misaligned_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_X_i         = 1'b0;
        func3_X_i        = 3'b000;
        byte_offset_X_i  = 2'b00;
        rd_X_i           = 5'd0;
        flush_i          = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = 32'h0;
    endtask

    task automatic present_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd);
        load_X_i        = 1'b1;
        func3_X_i       = f3;
        byte_offset_X_i = off;
        rd_X_i          = rd;
    endtask

    // One complete load from IDLE: capture, immediate response, check writeback.
    task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        present_load(f3, off, rd);
        cycle();
        idle_inputs();
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = rdata;
        cycle();
        idle_inputs();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== exp || wb_rd_o !== rd) begin
            errors++;
            $display("FAIL %s: valid=%0b data=%h rd=%0d, required valid=1 data=%h rd=%0d",
                     name, wb_valid_o, wb_data_o, wb_rd_o, exp, rd);
        end
        cycle();
        checks++;
        if (wb_valid_o !== 1'b0 || wb_data_o !== exp) begin
            errors++;
            $display("FAIL %s_hold: valid=%0b data=%h, required valid=0 data=%h",
                     name, wb_valid_o, wb_data_o, exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        checks++;
        if ({stall_o, wb_valid_o, misaligned_o} !== 3'b000 || wb_data_o !== 32'h0 || wb_rd_o !== 5'd0) begin
            errors++;
            $display("FAIL reset: stall=%0b valid=%0b mis=%0b data=%h rd=%0d, required all 0",
                     stall_o, wb_valid_o, misaligned_o, wb_data_o, wb_rd_o);
        end
    endtask

    task automatic test_bytes();
        do_load("lb_off3",  F3_LB,  2'd3, 5'd1, 32'h80FF_7F01, 32'hFFFF_FF80);
        do_load("lbu_off3", F3_LBU, 2'd3, 5'd2, 32'h80FF_7F01, 32'h0000_0080);
        do_load("lb_off0",  F3_LB,  2'd0, 5'd3, 32'h80FF_7F01, 32'h0000_0001);
        do_load("lb_off1",  F3_LB,  2'd1, 5'd4, 32'h80FF_7F01, 32'h0000_007F);
        do_load("lb_off2",  F3_LB,  2'd2, 5'd5, 32'h80FF_7F01, 32'hFFFF_FFFF);
    endtask

    task automatic test_halves_words();
        do_load("lh_off2",  F3_LH,  2'd2, 5'd6,  32'h8001_7FFE, 32'hFFFF_8001);
        do_load("lhu_off0", F3_LHU, 2'd0, 5'd7,  32'h8001_7FFE, 32'h0000_7FFE);
        do_load("lhu_off2", F3_LHU, 2'd2, 5'd8,  32'h8001_7FFE, 32'h0000_8001);
        do_load("lh_off0",  F3_LH,  2'd0, 5'd9,  32'h8001_7FFE, 32'h0000_7FFE);
        do_load("lw",       F3_LW,  2'd0, 5'd31, 32'h8001_7FFE, 32'h8001_7FFE);
    endtask

    task automatic test_misaligned();
        logic [2:0] f3s  [3] = '{F3_LW, 3'b011, F3_LH};
        logic [1:0] offs [3] = '{2'd1,  2'd0,   2'd1};
        for (int i = 0; i < 3; i++) begin
            present_load(f3s[i], offs[i], 5'd12);
            cycle();
            idle_inputs();
            checks++;
            if (misaligned_o !== 1'b1 || wb_valid_o !== 1'b0 || stall_o !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_%0d: mis=%0b valid=%0b stall=%0b, required mis=1 valid=0 stall=0",
                         i, misaligned_o, wb_valid_o, stall_o);
            end
            cycle();
            checks++;
            if (misaligned_o !== 1'b0 || stall_o !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_after_%0d: mis=%0b stall=%0b, required 0 0",
                         i, misaligned_o, stall_o);
            end
        end
    endtask

    task automatic test_stall();
        present_load(F3_LW, 2'd0, 5'd7);
        cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_o !== 1'b1 || wb_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_wait_%0d: stall=%0b valid=%0b, required stall=1 valid=0",
                         i, stall_o, wb_valid_o);
            end
            cycle();
        end
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'h1234_5678;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_on_resp: stall=%0b, required 0", stall_o);
        end
        cycle();
        idle_inputs();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd7 || wb_data_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL stall_result: valid=%0b rd=%0d data=%h, required 1 7 12345678",
                     wb_valid_o, wb_rd_o, wb_data_o);
        end
        cycle();
        checks++;
        if (wb_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_pulse_end: valid=%0b stall=%0b, required 0 0", wb_valid_o, stall_o);
        end
    endtask

    task automatic test_back_to_back();
        present_load(F3_LB, 2'd0, 5'd3);
        cycle();
        idle_inputs();
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'h0000_00F0;
        present_load(F3_LHU, 2'd2, 5'd4);
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hFFFF_FFF0 || wb_rd_o !== 5'd3 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: valid=%0b data=%h rd=%0d stall=%0b, required 1 fffffff0 3 1",
                     wb_valid_o, wb_data_o, wb_rd_o, stall_o);
        end
        cycle();
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'hABCD_0000;
        // Illegal load riding on the completing cycle: result and rejection together.
        present_load(F3_LW, 2'd2, 5'd9);
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_ABCD || wb_rd_o !== 5'd4 ||
            misaligned_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid=%0b data=%h rd=%0d mis=%0b stall=%0b, required 1 0000abcd 4 1 0",
                     wb_valid_o, wb_data_o, wb_rd_o, misaligned_o, stall_o);
        end
        cycle();
    endtask

    task automatic test_flush();
        present_load(F3_LW, 2'd0, 5'd9);
        cycle();
        idle_inputs();
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'hDEAD_BEEF;
        flush_i          = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: stall=%0b, required 0", stall_o);
        end
        cycle();
        flush_i = 1'b0;
        checks++;
        if (wb_valid_o !== 1'b0 || misaligned_o !== 1'b0 || wb_data_o === 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL flush_resp: valid=%0b mis=%0b data=%h, required no writeback",
                     wb_valid_o, misaligned_o, wb_data_o);
        end
        // Stale response arriving in IDLE.
        cycle();
        idle_inputs();
        checks++;
        if (wb_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stale_resp: valid=%0b stall=%0b, required 0 0", wb_valid_o, stall_o);
        end
        // Flushed load in IDLE is not captured; flush while waiting drops the load.
        present_load(F3_LW, 2'd0, 5'd10);
        flush_i = 1'b1;
        cycle();
        idle_inputs();
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_capture: stall=%0b, required 0", stall_o);
        end
        present_load(F3_LW, 2'd0, 5'd11);
        cycle();
        idle_inputs();
        flush_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_stall: stall=%0b, required 0", stall_o);
        end
        cycle();
        flush_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_idle: stall=%0b, required 0", stall_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_load("pre_rst_lw", F3_LW, 2'd0, 5'd21, 32'hCAFE_F00D, 32'hCAFE_F00D);
        present_load(F3_LW, 2'd0, 5'd22);
        cycle();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        checks++;
        if ({stall_o, wb_valid_o, misaligned_o} !== 3'b000 || wb_data_o !== 32'h0 || wb_rd_o !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_wait: stall=%0b valid=%0b mis=%0b data=%h rd=%0d, required all 0",
                     stall_o, wb_valid_o, misaligned_o, wb_data_o, wb_rd_o);
        end
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'h1111_1111;
        cycle();
        idle_inputs();
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_dropped_load: valid=%0b, required 0", wb_valid_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_bytes();
        test_halves_words();
        test_misaligned();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
